// File: rtl/par_to_ser.sv
// Purpose : N-bit parallel word to LSB-first serial stream with frame/done markers.
// Latency : din[0] appears on Dout the cycle after the load is accepted; N cycles per word.
// Backpr. : load_ready only in IDLE or on the last-bit cycle; load_valid is ignored otherwise.
//
// Ports:
//   clk        - clock, rising edge
//   asyn_clr   - asynchronous active-low clear
//   din        - parallel word, sampled on an accepted load
//   load_valid - producer has a word on din
//   load_ready - block accepts a word this cycle
//   Dout       - serial data bit (bit 0 of the shift register)
//   frame      - Dout carries a valid data bit
//   busy       - a word is held or being shifted
//   done       - last bit of the current word is on Dout
module par_to_ser #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         asyn_clr,
  input  logic [N-1:0] din,
  input  logic         load_valid,
  output logic         load_ready,
  output logic         Dout,
  output logic         frame,
  output logic         busy,
  output logic         done
);

  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    sh_q, sh_d;
  logic            last_bit;
  logic            accept;

  assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  // The shift register is kept at zero whenever the FSM is idle, so Dout can
  // come straight from bit 0 without any extra gating.
  assign Dout  = sh_q[0];
  assign frame = (state_q == SHIFT);
  assign busy  = (state_q == SHIFT);
  assign done  = last_bit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh_d    = din;
        end
      end
      SHIFT: begin
        if (accept) begin
          // Back-to-back word: reload on the last-bit cycle, frame stays high.
          cnt_d = '0;
          sh_d  = din;
        end else if (last_bit) begin
          state_d = IDLE;
          cnt_d   = '0;
          sh_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          sh_d  = {1'b0, sh_q[N-1:1]};
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sh_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge asyn_clr) begin
    if (!asyn_clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
    end
  end

endmodule

// File: tb/tb_par_to_ser.sv
// Directed bench for par_to_ser (N=8 and N=2 instances) with a serial-to-parallel
// receiver that collects recovered words during a randomized-load phase.
module tb_par_to_ser;

  logic       clk = 1'b0;
  logic       asyn_clr;
  logic [7:0] din8;
  logic       lv8, lr8, dout8, fr8, busy8, done8;
  logic [1:0] din2;
  logic       lv2, lr2, dout2, fr2, busy2, done2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  par_to_ser #(.N(8)) dut8 (
    .clk(clk), .asyn_clr(asyn_clr), .din(din8), .load_valid(lv8),
    .load_ready(lr8), .Dout(dout8), .frame(fr8), .busy(busy8), .done(done8)
  );

  par_to_ser #(.N(2)) dut2 (
    .clk(clk), .asyn_clr(asyn_clr), .din(din2), .load_valid(lv2),
    .load_ready(lr2), .Dout(dout2), .frame(fr2), .busy(busy2), .done(done2)
  );

  // Receiver: shifts Dout in LSB-first on every frame-high cycle.
  bit         sb_en = 1'b0;
  logic [7:0] rx_sr = '0;
  int         rx_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];

  always @(negedge clk) begin
    if (!sb_en || !asyn_clr) begin
      rx_cnt <= 0;
    end else if (fr8) begin
      rx_sr <= {dout8, rx_sr[7:1]};
      if (rx_cnt == 7) begin
        rxq.push_back({dout8, rx_sr[7:1]});
        rx_cnt <= 0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, "_dout"},  dout8, 0);
    chk({tag, "_frame"}, fr8,   0);
    chk({tag, "_busy"},  busy8, 0);
    chk({tag, "_done"},  done8, 0);
    chk({tag, "_ready"}, lr8,   1);
  endtask

  // Checks the 8 bit cycles of word w (the load must already be accepted).
  // churn: hold load_valid high with junk din during non-ready cycles.
  // On the last-bit cycle, present nxt_w if nxt_vld.
  task automatic exp_word8(input logic [7:0] w, input bit churn, input bit nxt_vld,
                           input logic [7:0] nxt_w, input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_b%0d_dout", tag, i),  dout8, w[i]);
      chk($sformatf("%s_b%0d_frame", tag, i), fr8,   1);
      chk($sformatf("%s_b%0d_busy", tag, i),  busy8, 1);
      chk($sformatf("%s_b%0d_done", tag, i),  done8, (i == 7));
      chk($sformatf("%s_b%0d_ready", tag, i), lr8,   (i == 7));
      if (i == 7) begin
        lv8  = nxt_vld;
        din8 = nxt_w;
      end else if (churn) begin
        lv8  = 1'b1;
        din8 = 8'($urandom);
      end else begin
        lv8 = 1'b0;
      end
      tick();
    end
  endtask

  logic [7:0] sb_w[20];
  bit         sb_b2b[20];

  initial begin
    asyn_clr = 1'b0;
    din8 = '0; lv8 = 1'b0;
    din2 = '0; lv2 = 1'b0;

    // Reset state
    #3;
    chk("rst_dout",  dout8, 0);
    chk("rst_frame", fr8,   0);
    chk("rst_busy",  busy8, 0);
    chk("rst_done",  done8, 0);
    @(negedge clk);
    asyn_clr = 1'b1;
    #1;
    chk_idle8("rel");

    // Single word A5 from IDLE
    din8 = 8'hA5; lv8 = 1'b1;
    tick();
    lv8 = 1'b0;
    exp_word8(8'hA5, 1'b0, 1'b0, 8'h00, "a5");
    chk_idle8("a5_end");

    // Back-to-back 01 then FF
    din8 = 8'h01; lv8 = 1'b1;
    tick();
    exp_word8(8'h01, 1'b0, 1'b1, 8'hFF, "w01");
    exp_word8(8'hFF, 1'b0, 1'b0, 8'h00, "wff");
    chk_idle8("b2b_end");

    // load_valid held with din churning during SHIFT
    din8 = 8'h5A; lv8 = 1'b1;
    tick();
    exp_word8(8'h5A, 1'b1, 1'b1, 8'hC3, "ch5a");
    exp_word8(8'hC3, 1'b1, 1'b0, 8'h00, "chc3");
    chk_idle8("churn_end");

    // Asynchronous clear mid-frame at bit 3 of F0
    din8 = 8'hF0; lv8 = 1'b1;
    tick();
    lv8 = 1'b0;
    tick(); tick(); tick();
    chk("f0_b3_frame", fr8,   1);
    chk("f0_b3_busy",  busy8, 1);
    #2;
    asyn_clr = 1'b0;
    #1;
    chk("clr_dout",  dout8, 0);
    chk("clr_frame", fr8,   0);
    chk("clr_busy",  busy8, 0);
    chk("clr_done",  done8, 0);
    din8 = 8'hFF; lv8 = 1'b1;
    tick(); tick();
    chk("clr_noload_frame", fr8,   0);
    chk("clr_noload_dout",  dout8, 0);
    lv8 = 1'b0;
    asyn_clr = 1'b1;
    chk_idle8("clr_rel");
    tick();
    chk_idle8("clr_rel2");
    din8 = 8'h3C; lv8 = 1'b1;
    tick();
    lv8 = 1'b0;
    exp_word8(8'h3C, 1'b0, 1'b0, 8'h00, "w3c");
    chk_idle8("w3c_end");

    // N=2 continuous stream 01,10,01,10
    din2 = 2'b01; lv2 = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      int b, wi;
      logic [1:0] w;
      b  = c % 2;
      wi = c / 2;
      w  = (wi % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("n2_c%0d_dout", c),  dout2, w[b]);
      chk($sformatf("n2_c%0d_frame", c), fr2,   1);
      chk($sformatf("n2_c%0d_done", c),  done2, b);
      chk($sformatf("n2_c%0d_ready", c), lr2,   b);
      if (b == 1) begin
        din2 = (wi % 2 == 0) ? 2'b10 : 2'b01;
        lv2  = (c != 7);
      end else begin
        din2 = 2'b11;
      end
      tick();
    end
    chk("n2_end_frame", fr2,   0);
    chk("n2_end_dout",  dout2, 0);
    chk("n2_end_busy",  busy2, 0);

    // Randomized loads with receiver scoreboard
    for (int k = 0; k < 20; k++) begin
      sb_w[k]   = 8'($urandom);
      sb_b2b[k] = (k > 0) && ($urandom_range(0, 1) == 1);
    end
    sb_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!sb_b2b[k]) begin
        repeat ($urandom_range(0, 2)) begin
          lv8 = 1'b0;
          tick();
        end
        din8 = sb_w[k]; lv8 = 1'b1;
        expq.push_back(sb_w[k]);
        tick();
      end
      for (int i = 0; i < 7; i++) begin
        lv8  = 1'($urandom_range(0, 1));
        din8 = 8'($urandom);
        tick();
      end
      if (k < 19 && sb_b2b[k + 1]) begin
        lv8 = 1'b1; din8 = sb_w[k + 1];
        expq.push_back(sb_w[k + 1]);
      end else begin
        lv8 = 1'b0;
      end
      tick();
    end
    lv8 = 1'b0;
    chk_idle8("sb_end");
    sb_en = 1'b0;
    chk("sb_count", rxq.size(), expq.size());
    for (int k = 0; k < expq.size() && k < rxq.size(); k++)
      chk($sformatf("sb_word%0d", k), rxq[k], expq[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/par_to_ser.md
PAR_TO_SER -- requirements
Module: par_to_ser

Interface
REQ-001 Parameter N, default 8: parallel word width, bits per frame; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 asyn_clr  input  1  reset, asynchronous, active-low; asserts immediately, deasserts synchronously to clk.
REQ-004 din  input  N  parallel word to serialize; sampled only on an accepted load.
REQ-005 load_valid  input  1  producer holds din valid.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 Dout  output  1  serial data bit, registered.
REQ-008 frame  output  1  high while Dout carries a valid data bit.
REQ-009 busy  output  1  high whenever a word is held or being shifted.
REQ-010 done  output  1  one-cycle pulse in the cycle the last bit of a word is on Dout.

Function
REQ-011 Load accepted on rising edge where load_valid=1 and load_ready=1; word captured into internal N-bit register.
REQ-012 Order: LSB first; din[0] on Dout first, din[N-1] last.
REQ-013 States: IDLE, SHIFT only.
REQ-014 IDLE: load_ready=1, frame=0, busy=0, Dout=0; accepted load -> SHIFT.
REQ-015 Latency: Dout=din[0] with frame=1 in the cycle after acceptance.
REQ-016 SHIFT: one bit per clock; bit counter 0..N-1, width ceil(log2(N)); counter wraps to 0 after N-1.
REQ-017 Exactly N consecutive frame-high cycles per word; no gaps, no repeats.
REQ-018 done=1 iff state=SHIFT and counter=N-1.
REQ-019 load_ready=1 in SHIFT only when counter=N-1 (last-bit cycle).
REQ-020 Back-to-back: accept on last-bit cycle -> next cycle Dout=new din[0], frame stays high, state stays SHIFT, counter=0.
REQ-021 No accept on last-bit cycle -> IDLE next cycle; frame=0, Dout=0.
REQ-022 load_valid with load_ready=0 ignored; din changes mid-frame do not affect the serial stream.
REQ-023 busy=1 in SHIFT, including the last-bit cycle.
REQ-024 Outputs Dout, frame, done, load_ready driven from registers/state only; no combinational path from din or load_valid to any output.

Reset
REQ-025 asyn_clr=0 forces immediately: state=IDLE, counter=0, shift register=0, Dout=0, frame=0, busy=0, done=0; load_ready=1 after release.
REQ-026 Reset mid-frame aborts the word; no residual bits after release; first accepted load after release starts a fresh frame at bit 0.
REQ-027 No load accepted while asyn_clr=0.

Verification
REQ-028 N=8, load din=8'hA5 from IDLE -> next 8 cycles Dout=1,0,1,0,0,1,0,1, frame=1 all 8, done only on cycle 8, then IDLE.
REQ-029 N=8, loads 8'h01 then 8'hFF on last-bit cycle -> 16 contiguous frame-high cycles, Dout=1,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1, two done pulses 8 cycles apart.
REQ-030 load_valid held high with din changing each cycle during SHIFT -> only words sampled on load_ready=1 edges serialized, stream unchanged by other din values.
REQ-031 asyn_clr pulled low mid-cycle at bit 3 of 8'hF0 -> Dout, frame, busy, done 0 without waiting for clk; after release, load 8'h3C -> Dout=0,0,1,1,1,1,0,0.
REQ-032 N=2, continuous load_valid with alternating 2'b01/2'b10 -> Dout=1,0,0,1 repeating, frame never drops, done every second cycle.
REQ-033 Scoreboard: a serial-to-parallel receiver (N-bit serial shift register clocked on frame) recovers every accepted din exactly, in order, under randomized load_valid.
